// File: rtl/spi_pkg.sv
// Shared definitions for the SPI chip-select sequencer and the SPI byte master:
// sequencer state encoding, SPI mode encodings and the post-forward ready guard length.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        TRANSFER    = 2'd1,
        CS_HOLD     = 2'd2,
        CS_INACTIVE = 2'd3
    } seq_state_t;

    // CPOL/CPHA pairs, identical to the master's SPI_MODE parameter values.
    localparam logic [1:0] SPI_MODE_0 = 2'd0;
    localparam logic [1:0] SPI_MODE_1 = 2'd1;
    localparam logic [1:0] SPI_MODE_2 = 2'd2;
    localparam logic [1:0] SPI_MODE_3 = 2'd3;

    // The master registers its ready drop, so ready is untrustworthy this long after a forward.
    localparam int READY_GUARD_CLKS = 2;

endpackage

// File: rtl/spi_cs_timer.sv
// Loadable down-counter; o_Done flags the final counted cycle (count of 1 or less).
// Shared by the CS hold, CS inactive and inter-byte timeout intervals.
module spi_cs_timer #(
    parameter int W = 8
) (
    input  logic         i_Clk,
    input  logic         i_Rst_L,
    input  logic         i_Load,
    input  logic [W-1:0] i_Load_Val,
    input  logic         i_En,
    output logic         o_Done
);

    logic [W-1:0] count;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            count <= '0;
        end else if (i_Load) begin
            count <= i_Load_Val;
        end else if (i_En && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign o_Done = (count <= W'(1));

endmodule

// File: rtl/spi_cs_sequencer.sv
// Chip-select sequencer in front of the SPI byte master: meters bytes, counts replies,
// enforces CS hold/inactive gaps. Optional inter-byte timeout under SPI_CS_TIMEOUT_EN.
module spi_cs_sequencer
    import spi_pkg::*;
#(
    parameter int MAX_BYTES_PER_CS = 2,
    parameter int CS_HOLD_CLKS     = 2,
    parameter int CS_INACTIVE_CLKS = 4,
    parameter int TIMEOUT_CLKS     = 256,
    localparam int CNT_W           = $clog2(MAX_BYTES_PER_CS + 1)
) (
    input  logic             i_Clk,
    input  logic             i_Rst_L,
    input  logic [CNT_W-1:0] i_TX_Count,
    input  logic [7:0]       i_TX_Byte,
    input  logic             i_TX_DV,
    output logic             o_TX_Ready,
    output logic [CNT_W-1:0] o_RX_Count,
    output logic             o_RX_DV,
    output logic [7:0]       o_RX_Byte,
    output logic [7:0]       o_M_TX_Byte,
    output logic             o_M_TX_DV,
    input  logic             i_M_TX_Ready,
    input  logic             i_M_RX_DV,
    input  logic [7:0]       i_M_RX_Byte,
    output logic             o_SPI_CS_n
`ifdef SPI_CS_TIMEOUT_EN
    ,
    output logic             o_Timeout
`endif
);

    localparam int TMR_MAX_A = (CS_HOLD_CLKS > CS_INACTIVE_CLKS) ? CS_HOLD_CLKS : CS_INACTIVE_CLKS;
    localparam int TMR_MAX   = (TIMEOUT_CLKS > TMR_MAX_A) ? TIMEOUT_CLKS : TMR_MAX_A;
    localparam int TMR_W     = $clog2(TMR_MAX + 1);

    localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_BYTES_PER_CS);
    localparam logic [CNT_W-1:0] ONE_CNT    = CNT_W'(1);
    localparam logic [1:0]       GUARD_INIT = 2'(READY_GUARD_CLKS);

    seq_state_t       state;
    logic [CNT_W-1:0] remaining;
    logic [1:0]       guard;

    logic             tx_accept;
    logic             ready_ok;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_en;
    logic             tmr_done;

    function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] c);
        if (c == '0)
            return ONE_CNT;
        else if (c > MAX_CNT)
            return MAX_CNT;
        else
            return c;
    endfunction

    assign tx_accept = i_TX_DV && o_TX_Ready && (state == IDLE || state == TRANSFER);
    assign ready_ok  = i_M_TX_Ready && (guard == 2'd0);

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_en   = 1'b0;
        case (state)
            IDLE, TRANSFER: begin
                if (tx_accept) begin
`ifdef SPI_CS_TIMEOUT_EN
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(TIMEOUT_CLKS);
`endif
                end else if (state == TRANSFER && remaining == '0 && ready_ok) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(CS_HOLD_CLKS);
                end else begin
`ifdef SPI_CS_TIMEOUT_EN
                    tmr_en = (state == TRANSFER) && (remaining != '0);
`endif
                end
            end
            CS_HOLD: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(CS_INACTIVE_CLKS);
                end else begin
                    tmr_en = 1'b1;
                end
            end
            CS_INACTIVE: tmr_en = 1'b1;
            default: tmr_en = 1'b0;
        endcase
    end

    spi_cs_timer #(.W(TMR_W)) u_timer (
        .i_Clk      (i_Clk),
        .i_Rst_L    (i_Rst_L),
        .i_Load     (tmr_load),
        .i_Load_Val (tmr_val),
        .i_En       (tmr_en),
        .o_Done     (tmr_done)
    );

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state       <= IDLE;
            remaining   <= '0;
            guard       <= 2'd0;
            o_SPI_CS_n  <= 1'b1;
            o_TX_Ready  <= 1'b0;
            o_M_TX_DV   <= 1'b0;
            o_M_TX_Byte <= 8'h00;
            o_RX_DV     <= 1'b0;
            o_RX_Byte   <= 8'h00;
            o_RX_Count  <= '0;
`ifdef SPI_CS_TIMEOUT_EN
            o_Timeout   <= 1'b0;
`endif
        end else begin
            o_M_TX_DV <= 1'b0;
            o_RX_DV   <= i_M_RX_DV;
`ifdef SPI_CS_TIMEOUT_EN
            o_Timeout <= 1'b0;
`endif
            if (i_M_RX_DV) begin
                o_RX_Byte <= i_M_RX_Byte;
                if (o_RX_Count != MAX_CNT)
                    o_RX_Count <= o_RX_Count + ONE_CNT;
            end
            if (guard != 2'd0)
                guard <= guard - 2'd1;

            case (state)
                IDLE: begin
                    o_SPI_CS_n <= 1'b1;
                    o_TX_Ready <= i_M_TX_Ready;
                    if (tx_accept) begin
                        // A new transaction's count clear overrides any RX increment above.
                        remaining   <= clamp_count(i_TX_Count) - ONE_CNT;
                        o_RX_Count  <= '0;
                        o_SPI_CS_n  <= 1'b0;
                        o_M_TX_DV   <= 1'b1;
                        o_M_TX_Byte <= i_TX_Byte;
                        o_TX_Ready  <= 1'b0;
                        guard       <= GUARD_INIT;
                        state       <= TRANSFER;
                    end
                end
                TRANSFER: begin
                    if (tx_accept) begin
                        remaining   <= remaining - ONE_CNT;
                        o_M_TX_DV   <= 1'b1;
                        o_M_TX_Byte <= i_TX_Byte;
                        o_TX_Ready  <= 1'b0;
                        guard       <= GUARD_INIT;
                    end else if (remaining == '0) begin
                        o_TX_Ready <= 1'b0;
                        if (ready_ok)
                            state <= CS_HOLD;
`ifdef SPI_CS_TIMEOUT_EN
                    end else if (tmr_done) begin
                        o_Timeout  <= 1'b1;
                        remaining  <= '0;
                        o_TX_Ready <= 1'b0;
`endif
                    end else begin
                        o_TX_Ready <= ready_ok;
                    end
                end
                CS_HOLD: begin
                    o_TX_Ready <= 1'b0;
                    if (tmr_done) begin
                        o_SPI_CS_n <= 1'b1;
                        state      <= CS_INACTIVE;
                    end
                end
                CS_INACTIVE: begin
                    o_TX_Ready <= 1'b0;
                    if (tmr_done)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cs_sequencer.sv
// Scoreboard bench for spi_cs_sequencer with a behavioural byte-master loopback model.
// Define SPI_CS_TIMEOUT_EN to also exercise the inter-byte timeout.
module tb_spi_cs_sequencer;

    localparam int MAX_B    = 2;
    localparam int HOLD     = 2;
    localparam int INACTIVE = 4;
`ifdef SPI_CS_TIMEOUT_EN
    localparam int TB_TIMEOUT = 16;
`else
    localparam int TB_TIMEOUT = 256;
`endif
    localparam int CNT_W = $clog2(MAX_B + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [CNT_W-1:0] i_TX_Count = '0;
    logic [7:0]       i_TX_Byte = 8'h00;
    logic             i_TX_DV = 1'b0;
    logic             o_TX_Ready;
    logic [CNT_W-1:0] o_RX_Count;
    logic             o_RX_DV;
    logic [7:0]       o_RX_Byte;
    logic [7:0]       o_M_TX_Byte;
    logic             o_M_TX_DV;
    logic             m_ready = 1'b1;
    logic             m_rx_dv = 1'b0;
    logic [7:0]       m_rx_byte = 8'h00;
    logic             o_SPI_CS_n;
`ifdef SPI_CS_TIMEOUT_EN
    logic             o_Timeout;
`endif

    spi_cs_sequencer #(
        .MAX_BYTES_PER_CS (MAX_B),
        .CS_HOLD_CLKS     (HOLD),
        .CS_INACTIVE_CLKS (INACTIVE),
        .TIMEOUT_CLKS     (TB_TIMEOUT)
    ) dut (
        .i_Clk        (clk),
        .i_Rst_L      (rst_n),
        .i_TX_Count   (i_TX_Count),
        .i_TX_Byte    (i_TX_Byte),
        .i_TX_DV      (i_TX_DV),
        .o_TX_Ready   (o_TX_Ready),
        .o_RX_Count   (o_RX_Count),
        .o_RX_DV      (o_RX_DV),
        .o_RX_Byte    (o_RX_Byte),
        .o_M_TX_Byte  (o_M_TX_Byte),
        .o_M_TX_DV    (o_M_TX_DV),
        .i_M_TX_Ready (m_ready),
        .i_M_RX_DV    (m_rx_dv),
        .i_M_RX_Byte  (m_rx_byte),
        .o_SPI_CS_n   (o_SPI_CS_n)
`ifdef SPI_CS_TIMEOUT_EN
        ,
        .o_Timeout    (o_Timeout)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    int         exp_cyc_q[$];
    logic [7:0] exp_rx_q[$];
    int         exp_cnt_q[$];

    int rx_in_txn    = 0;
    int m_ready_rise = 0;
    int last_fwd_cyc = 0;
    int timeout_cyc  = -1;
    bit timeout_seen = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic chk_ge(input string name, input int act, input int lo);
        checks++;
        if (act < lo) begin
            errors++;
            $display("FAIL %s: got %0d expected at least %0d at cycle %0d", name, act, lo, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    endtask

    // ---------------- byte-master model ----------------
    // Ready stays stale through the forward cycle and the next, then drops; after a
    // random busy time the sent byte loops back as RX, then ready returns.
    initial begin : master_model
        int phase;
        int busy;
        logic [7:0] m_byte;
        phase = 0;
        busy = 0;
        m_byte = 8'h00;
        forever begin
            @(negedge clk);
            m_rx_dv = 1'b0;
            if (!rst_n) begin
                m_ready = 1'b1;
                phase = 0;
                busy = 0;
            end else begin
                case (phase)
                    0: if (o_M_TX_DV) begin
                        m_byte = o_M_TX_Byte;
                        phase = 1;
                    end
                    1: begin
                        m_ready = 1'b0;
                        busy = $urandom_range(2, 5);
                        phase = 2;
                    end
                    2: if (busy > 0) begin
                        busy--;
                    end else begin
                        m_rx_dv = 1'b1;
                        m_rx_byte = m_byte;
                        rx_in_txn++;
                        exp_rx_q.push_back(m_byte);
                        exp_cnt_q.push_back((rx_in_txn > MAX_B) ? MAX_B : rx_in_txn);
                        phase = 3;
                    end
                    default: begin
                        m_ready = 1'b1;
                        m_ready_rise = cyc;
                        phase = 0;
                    end
                endcase
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        int guard_win;
        int cs_high_cnt;
        int ref_cyc;
        logic cs_prev;
        logic [7:0] eb;
        int ec;
        guard_win = 0;
        cs_high_cnt = 1000;
        cs_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                guard_win = 0;
                cs_high_cnt = 1000;
                cs_prev = 1'b1;
            end else begin
                if (o_M_TX_DV) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_forward");
                    end else begin
                        eb = exp_q.pop_front();
                        ec = exp_cyc_q.pop_front();
                        chk("fwd_byte", int'(o_M_TX_Byte), int'(eb));
                        chk("fwd_latency", cyc - ec, 1);
                        chk("fwd_cs_low", int'(o_SPI_CS_n), 0);
                    end
                    last_fwd_cyc = cyc;
                    guard_win = 2;
                end else if (guard_win > 0) begin
                    chk("stale_ready_guard", int'(o_TX_Ready), 0);
                    guard_win--;
                end
                if (o_RX_DV) begin
                    if (exp_rx_q.size() == 0) begin
                        fail_now("unexpected_rx");
                    end else begin
                        eb = exp_rx_q.pop_front();
                        ec = exp_cnt_q.pop_front();
                        chk("rx_byte", int'(o_RX_Byte), int'(eb));
                        chk("rx_count", int'(o_RX_Count), ec);
                    end
                end
`ifdef SPI_CS_TIMEOUT_EN
                if (o_Timeout) begin
                    chk("timeout_cycle", cyc - last_fwd_cyc, TB_TIMEOUT);
                    timeout_cyc = cyc;
                    timeout_seen = 1'b1;
                end
`endif
                if (!cs_prev && o_SPI_CS_n) begin
                    ref_cyc = (timeout_cyc > m_ready_rise) ? timeout_cyc : m_ready_rise;
                    chk("cs_hold", cyc - ref_cyc, HOLD + 1);
                    cs_high_cnt = 0;
                end
                if (cs_prev && !o_SPI_CS_n)
                    chk_ge("cs_inactive_gap", cs_high_cnt, INACTIVE);
                if (o_SPI_CS_n) begin
                    if (cs_high_cnt < INACTIVE)
                        chk("inactive_ready", int'(o_TX_Ready), 0);
                    cs_high_cnt++;
                end
                cs_prev = o_SPI_CS_n;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (o_TX_Ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok)
            fail_now("wait_tx_ready");
    endtask

    task automatic send_byte(input int count, input bit first, input logic [7:0] b);
        i_TX_DV = 1'b1;
        i_TX_Byte = b;
        i_TX_Count = first ? CNT_W'(count) : CNT_W'($urandom);
        if (first)
            rx_in_txn = 0;
        exp_q.push_back(b);
        exp_cyc_q.push_back(cyc);
        @(negedge clk);
        i_TX_DV = 1'b0;
    endtask

    // count: requested count; ntry: bytes the user tries to send; inject: illegal
    // pulses in the two cycles following each accepted byte.
    task automatic send_txn(input int count, input int ntry, input bit inject,
                            input logic [7:0] b0, input logic [7:0] b1);
        int eff;
        bit ok;
        bit done;
        logic [7:0] b;
        eff = (count == 0) ? 1 : ((count > MAX_B) ? MAX_B : count);
        for (int i = 0; i < eff; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            wait_ready(ok);
            if (!ok)
                return;
            b = (i == 0) ? b0 : ((i == 1) ? b1 : 8'($urandom));
            send_byte(count, i == 0, b);
            if (inject) begin
                i_TX_DV = 1'b1;
                i_TX_Byte = ~b;
                @(negedge clk);
                @(negedge clk);
                i_TX_DV = 1'b0;
            end
        end
        done = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            i_TX_DV = 1'b0;
            if (o_SPI_CS_n) begin
                done = 1'b1;
                break;
            end
            chk("ready_after_last", int'(o_TX_Ready), 0);
            if (ntry > eff && k == 2) begin
                i_TX_DV = 1'b1;
                i_TX_Byte = 8'($urandom);
            end
        end
        i_TX_DV = 1'b0;
        if (!done)
            fail_now("cs_rise");
        chk("rx_count_final", int'(o_RX_Count), eff);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        bit ok;
        int cnt;
        repeat (2) @(negedge clk);
        chk("rst_cs_n", int'(o_SPI_CS_n), 1);
        chk("rst_tx_ready", int'(o_TX_Ready), 0);
        chk("rst_m_tx_dv", int'(o_M_TX_DV), 0);
        chk("rst_m_tx_byte", int'(o_M_TX_Byte), 0);
        chk("rst_rx_dv", int'(o_RX_DV), 0);
        chk("rst_rx_byte", int'(o_RX_Byte), 0);
        chk("rst_rx_count", int'(o_RX_Count), 0);
`ifdef SPI_CS_TIMEOUT_EN
        chk("rst_timeout", int'(o_Timeout), 0);
`endif
        #2 rst_n = 1'b1;

        send_txn(1, 1, 1'b0, 8'hA5, 8'h00);
        send_txn(2, 2, 1'b0, 8'h12, 8'h34);
        send_txn(0, 1, 1'b0, 8'h5A, 8'h00);
        send_txn(3, 3, 1'b0, 8'hC3, 8'h3C);
        send_txn(2, 2, 1'b1, 8'h81, 8'h7E);

        for (int t = 0; t < 20; t++) begin
            cnt = $urandom_range(0, 3);
            send_txn(cnt, $urandom_range(1, 3), 1'($urandom_range(0, 1)),
                     8'($urandom), 8'($urandom));
        end

        // Asynchronous reset in the middle of a two-byte transaction.
        wait_ready(ok);
        if (ok) begin
            send_byte(2, 1'b1, 8'h99);
            #2 rst_n = 1'b0;
            #1;
            chk("mid_rst_cs_n", int'(o_SPI_CS_n), 1);
            chk("mid_rst_tx_ready", int'(o_TX_Ready), 0);
            chk("mid_rst_m_tx_dv", int'(o_M_TX_DV), 0);
            chk("mid_rst_rx_count", int'(o_RX_Count), 0);
            exp_q.delete();
            exp_cyc_q.delete();
            exp_rx_q.delete();
            exp_cnt_q.delete();
            rx_in_txn = 0;
            repeat (2) @(negedge clk);
            #2 rst_n = 1'b1;
            @(negedge clk);
            chk("post_rst_cs_n", int'(o_SPI_CS_n), 1);
            chk("post_rst_rx_count", int'(o_RX_Count), 0);
            chk("post_rst_m_tx_dv", int'(o_M_TX_DV), 0);
        end
        send_txn(2, 2, 1'b0, 8'h0F, 8'hF0);

`ifdef SPI_CS_TIMEOUT_EN
        // Send one byte of two, then stall until the inter-byte timeout closes the transaction.
        wait_ready(ok);
        if (ok) begin
            timeout_seen = 1'b0;
            send_byte(2, 1'b1, 8'h66);
            ok = 1'b0;
            for (int k = 0; k < 200; k++) begin
                @(negedge clk);
                if (o_SPI_CS_n) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok)
                fail_now("timeout_cs_rise");
            chk("timeout_seen", int'(timeout_seen), 1);
            chk("timeout_rx_count", int'(o_RX_Count), 1);
        end
        send_txn(2, 2, 1'b0, 8'h24, 8'h42);
`endif

        repeat (10) @(negedge clk);
        chk("fwd_queue_empty", exp_q.size(), 0);
        chk("rx_queue_empty", exp_rx_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_cs_sequencer.md
Name: spi_cs_sequencer

Overview:
- Upstream control stage for the SPI byte master (the byte-level engine: i_TX_DV/i_TX_Byte in, o_TX_Ready/o_RX_DV/o_RX_Byte out).
- Wraps multi-byte transactions: drives active-low chip-select, meters bytes into the master, counts returned bytes, and enforces CS hold and inactive gaps.
- Sits between the user/command logic and the byte master. The master is not instantiated here; its ports connect to the master-side ports below.

Parameters:
- MAX_BYTES_PER_CS, 2, maximum bytes in one CS-low transaction (>= 1).
- CS_HOLD_CLKS, 2, i_Clk cycles CS stays low after the master reports ready following the last byte (>= 1).
- CS_INACTIVE_CLKS, 4, minimum i_Clk cycles CS stays high between transactions (>= 1).
- TIMEOUT_CLKS, 256, inter-byte timeout. Used only with the optional feature.
- Local: CNT_W = $clog2(MAX_BYTES_PER_CS+1).

Ports:
- i_Clk  in  1  system clock.
- i_Rst_L  in  1  asynchronous active-low reset.
- i_TX_Count  in  CNT_W  bytes in the transaction; sampled only on the first i_TX_DV in IDLE.
- i_TX_Byte  in  8  byte to send.
- i_TX_DV  in  1  single-cycle byte-valid pulse; legal only while o_TX_Ready=1.
- o_TX_Ready  out  1  sequencer can accept a byte.
- o_RX_Count  out  CNT_W  bytes received in the current transaction.
- o_RX_DV  out  1  one-cycle pulse per received byte.
- o_RX_Byte  out  8  received byte, valid with o_RX_DV.
- o_M_TX_Byte  out  8  byte to master.
- o_M_TX_DV  out  1  one-cycle pulse to master.
- i_M_TX_Ready  in  1  master ready.
- i_M_RX_DV  in  1  master byte-received pulse.
- i_M_RX_Byte  in  8  master received byte.
- o_SPI_CS_n  out  1  chip select, active low.

Behaviour:
- Reset (asynchronous, any state, including mid-transfer):
  - state=IDLE, o_SPI_CS_n=1, o_TX_Ready=0.
  - o_M_TX_DV=0, o_M_TX_Byte=0, o_RX_DV=0, o_RX_Byte=0, o_RX_Count=0.
  - Internal counters cleared.
- All outputs are registered.
- States: IDLE, TRANSFER, CS_HOLD, CS_INACTIVE.
- IDLE:
  - o_SPI_CS_n=1; o_TX_Ready = i_M_TX_Ready (registered, 1-cycle lag).
  - On i_TX_DV: latch remaining = i_TX_Count, clamped so that 0 becomes 1 and values above MAX_BYTES_PER_CS become MAX_BYTES_PER_CS.
  - Same cycle, also: next cycle o_SPI_CS_n=0, o_M_TX_DV=1, o_M_TX_Byte=i_TX_Byte; remaining decrements; o_RX_Count clears to 0; go to TRANSFER.
- Forwarding latency: i_TX_DV to o_M_TX_DV is exactly 1 cycle; CS falls in the same cycle as o_M_TX_DV.
- Stale-ready guard: after any o_M_TX_DV, i_M_TX_Ready is ignored for 2 cycles, because the master's ready drop is registered.
- TRANSFER:
  - o_TX_Ready = (remaining>0) & i_M_TX_Ready (post-guard).
  - i_TX_DV forwards the byte as in IDLE and decrements remaining.
  - When remaining==0 and i_M_TX_Ready is seen (post-guard), go to CS_HOLD.
- CS_HOLD: CS stays low for CS_HOLD_CLKS cycles, then o_SPI_CS_n=1 and go to CS_INACTIVE. o_TX_Ready=0.
- CS_INACTIVE: count CS_INACTIVE_CLKS cycles with o_TX_Ready=0, then go to IDLE.
- RX path, in any state:
  - i_M_RX_DV produces o_RX_DV one cycle later, with o_RX_Byte = i_M_RX_Byte.
  - o_RX_Count increments, saturating at MAX_BYTES_PER_CS.
  - RX pulses in CS_HOLD are still forwarded (the last byte's RX_DV precedes ready).
- Illegal input: i_TX_DV while o_TX_Ready=0 is ignored (no forward, no count change).
- Simultaneous events: the RX increment and the o_RX_Count clear on a new-transaction start cannot coincide, because CS_INACTIVE separates them. If they did, the clear wins.

Optional Feature:
- Macro: SPI_CS_TIMEOUT_EN.
- With it defined:
  - Adds output o_Timeout (1 bit, reset 0).
  - In TRANSFER, an inter-byte counter runs while remaining>0 and no i_TX_DV arrives. It clears on each forwarded byte.
  - When the counter reaches TIMEOUT_CLKS, pulse o_Timeout for 1 cycle, set remaining=0, and go to CS_HOLD as soon as i_M_TX_Ready is seen.
- Without it: no port, no counter; the sequencer waits indefinitely for the next byte with CS low.

Decomposition:
- Package spi_pkg: state enum typedef (IDLE, TRANSFER, CS_HOLD, CS_INACTIVE) and the SPI mode encoding constants shared with the master.
- One natural sub-module: spi_cs_timer, a loadable down-counter with a done flag. It is reused for the CS_HOLD, CS_INACTIVE and timeout counts.

Test Plan:
1. Single byte, count=1: i_TX_DV with 0xA5 → next cycle o_M_TX_DV=1, o_M_TX_Byte=0xA5, CS_n=0. After master ready plus 2 cycles, CS_n=1. CS_n stays high >= 4 cycles before o_TX_Ready=1.
2. Two bytes, count=2: send 0x12 then 0x34 → CS_n stays low across both. The master receives two DV pulses. Loopback MISO gives o_RX_DV twice with 0x12, 0x34 and final o_RX_Count=2.
3. Count=0 → treated as 1. Count=3 with MAX=2 → only 2 bytes accepted, and o_TX_Ready stays 0 after the second byte.
4. Stale ready: verify no second o_M_TX_DV is accepted during the 2-cycle guard, even if i_TX_DV is pulsed in the cycle right after forwarding.
5. Reset asserted mid-transaction after byte 1 of 2 → o_SPI_CS_n=1 immediately (asynchronous). After release: IDLE, o_RX_Count=0.
6. With SPI_CS_TIMEOUT_EN, TIMEOUT_CLKS=16: count=2, send one byte, then stall → o_Timeout pulses at cycle 16 after the byte is forwarded, and CS_n rises CS_HOLD_CLKS cycles after master ready.
